// File: rtl/max5216_ramp_ctrl_if.sv
// max5216_ramp_ctrl_if: write handshake between the ramp controller and the MAX5216 SPI engine.
interface max5216_ramp_ctrl_if;
    logic        data_in_en;
    logic [15:0] data_in;
    logic        spi_ok;

    modport master (output data_in_en, output data_in, input spi_ok);
    modport slave  (input data_in_en, input data_in, output spi_ok);
endinterface

// File: rtl/max5216_ramp_ctrl.sv
// max5216_ramp_ctrl: steps the DAC code toward a target in bounded increments,
// one confirmed SPI write at a time, with a per-write completion timeout.
module max5216_ramp_ctrl #(
    parameter logic [15:0] INIT_CODE   = 16'h8000,
    parameter logic [15:0] HOLD_CYC    = 16'd100,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       target_en,
    input  logic [15:0]                target_data,
    input  logic [15:0]                step_size,
    max5216_ramp_ctrl_if.master        spi,
    output logic [15:0]                dac_code_cur,
    output logic                       ramp_busy,
    output logic                       ramp_done,
    output logic                       timeout_err
);
    typedef enum logic [2:0] {IDLE, CALC, SEND, WAIT_OK, HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_tgt, r_cur, r_next, r_data_in, r_cnt;
    logic        r_data_in_en, r_done, r_terr;
    logic [15:0] w_tgt_eff, w_calc;
    logic [16:0] w_diff, w_sum, w_cnt_inc;
    logic        w_gt, w_clamp, w_tmo, w_hold_end, w_stay;

    // a target arriving alongside spi_ok supersedes the old one for the done decision
    assign w_tgt_eff  = target_en ? target_data : r_tgt;
    assign w_gt       = r_tgt > r_cur;
    assign w_diff     = w_gt ? {1'b0, r_tgt} - {1'b0, r_cur} : {1'b0, r_cur} - {1'b0, r_tgt};
    assign w_sum      = w_gt ? {1'b0, r_cur} + {1'b0, step_size} : {1'b0, r_cur} - {1'b0, step_size};
    assign w_clamp    = step_size == 16'd0 || w_diff <= {1'b0, step_size} || w_sum[16];
    assign w_calc     = w_clamp ? r_tgt : w_sum[15:0];
    assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
    assign w_tmo      = w_cnt_inc >= {1'b0, TIMEOUT_CYC};
    // w_cnt_inc is never below 1, so HOLD_CYC=0 behaves as a single hold clock
    assign w_hold_end = w_cnt_inc >= {1'b0, HOLD_CYC};
    assign w_stay     = w_state_nxt == r_state && (r_state == WAIT_OK || r_state == HOLD);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = target_en ? CALC : IDLE;
            CALC:    w_state_nxt = SEND;
            SEND:    w_state_nxt = WAIT_OK;
            WAIT_OK: w_state_nxt = spi.spi_ok ? (r_next == w_tgt_eff ? IDLE : HOLD)
                                              : (w_tmo ? IDLE : WAIT_OK);
            HOLD:    w_state_nxt = w_hold_end ? CALC : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tgt        <= INIT_CODE;
            r_cur        <= INIT_CODE;
            r_next       <= INIT_CODE;
            r_data_in    <= '0;
            r_cnt        <= '0;
            r_data_in_en <= 1'b0;
            r_done       <= 1'b0;
            r_terr       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_in_en <= r_state == SEND;
            r_done       <= r_state == WAIT_OK && spi.spi_ok && r_next == w_tgt_eff;
            r_cnt        <= w_stay ? r_cnt + 16'd1 : 16'd0;
            if (target_en)
                r_tgt <= target_data;
            if (r_state == CALC)
                r_next <= w_calc;
            if (r_state == SEND)
                r_data_in <= r_next;
            if (r_state == IDLE && target_en)
                r_terr <= 1'b0;
            else if (r_state == WAIT_OK && !spi.spi_ok && w_tmo)
                r_terr <= 1'b1;
            if (r_state == WAIT_OK && spi.spi_ok)
                r_cur <= r_next;
        end
    end

    assign spi.data_in_en = r_data_in_en;
    assign spi.data_in    = r_data_in;
    assign dac_code_cur   = r_cur;
    assign ramp_busy      = r_state != IDLE;
    assign ramp_done      = r_done;
    assign timeout_err    = r_terr;
endmodule

// File: tb/tb_max5216_ramp_ctrl.sv
// tb_max5216_ramp_ctrl: scoreboard bench; a ramp model queues the expected write codes
// and a monitor pops and compares them as the controller issues writes.
`timescale 1ns/1ps
module tb_max5216_ramp_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, target_en = 1'b0;
    logic [15:0] target_data = '0, step_size = '0;
    logic [15:0] dac_code_cur;
    logic        ramp_busy, ramp_done, timeout_err;
    logic        resp_ok = 1'b0, man_ok = 1'b0, ok_en = 1'b1, pending = 1'b0;
    logic [15:0] last_wr = '0;
    logic [15:0] exp_q[$];
    int          ok_delay = 5, n_chk = 0, n_fail = 0, n_done = 0;

    max5216_ramp_ctrl_if bus();
    assign bus.spi_ok = resp_ok | man_ok;

    max5216_ramp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .target_en(target_en), .target_data(target_data),
        .step_size(step_size), .spi(bus), .dac_code_cur(dac_code_cur),
        .ramp_busy(ramp_busy), .ramp_done(ramp_done), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // independent model of the ramp: every target produces at least one write
    task automatic push_ramp(input logic [15:0] cur, input logic [15:0] tgt, input logic [15:0] step);
        int c = int'(cur);
        int t = int'(tgt);
        int s = int'(step);
        do begin
            if (s == 0 || (t > c ? t - c : c - t) <= s) c = t;
            else c = t > c ? c + s : c - s;
            exp_q.push_back(16'(c));
        end while (c != t);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [15:0] t, input logic [15:0] s);
        target_data = t;
        step_size   = s;
        target_en   = 1'b1;
        tick(1);
        target_en   = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (ramp_busy && n < lim) begin
            tick(1);
            n++;
        end
        chk("idle_bound", ramp_busy, 0);
        tick(2);
    endtask

    task automatic wait_wr(input int lim);
        int n = 0;
        while (!bus.data_in_en && n < lim) begin
            tick(1);
            n++;
        end
        chk("wr_bound", bus.data_in_en, 1);
    endtask

    // spi engine model: answers each write after ok_delay clocks unless disabled or reset
    initial forever begin
        @(posedge clk);
        #1;
        resp_ok = 1'b0;
        if (rst_n && ok_en && bus.data_in_en) begin
            for (int i = 0; i < ok_delay && rst_n; i++) begin
                @(posedge clk);
                #1;
            end
            if (rst_n) resp_ok = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!ramp_busy) pending = 1'b0;
        if (ramp_done) n_done++;
        if (bus.spi_ok && pending) begin
            chk("data_hold", bus.data_in, last_wr);
            pending = 1'b0;
        end
        if (bus.data_in_en) begin
            chk("overlap", pending, 0);
            if (exp_q.size() == 0) chk("wr_unexpected", exp_q.size(), 1);
            else chk("wr_data", bus.data_in, exp_q.pop_front());
            last_wr = bus.data_in;
            pending = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, n;
        tick(3);
        chk("rst_en", bus.data_in_en, 0);
        chk("rst_data", bus.data_in, 16'h0000);
        chk("rst_busy", ramp_busy, 0);
        chk("rst_done", ramp_done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_cur", dac_code_cur, 16'h8000);
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_busy", ramp_busy, 0);

        // upward ramp with slow spi: latency and four steps
        ok_delay = 250;
        d0 = n_done;
        push_ramp(16'h8000, 16'h8100, 16'h0040);
        go(16'h8100, 16'h0040);
        n = 1;
        while (!bus.data_in_en && n < 10) begin
            tick(1);
            n++;
        end
        chk("latency", n, 3);
        wait_idle(5000);
        chk("up_cur", dac_code_cur, 16'h8100);
        chk("up_done", n_done - d0, 1);
        chk("up_q", exp_q.size(), 0);

        // downward clamp
        ok_delay = 5;
        push_ramp(16'h8100, 16'h8000, 16'h0000);
        go(16'h8000, 16'h0000);
        wait_idle(500);
        d0 = n_done;
        push_ramp(16'h8000, 16'h7FF0, 16'h0020);
        go(16'h7FF0, 16'h0020);
        wait_idle(500);
        chk("dn_cur", dac_code_cur, 16'h7FF0);
        chk("dn_done", n_done - d0, 1);

        // full-scale jump with step 0, then same-code target
        push_ramp(16'h7FF0, 16'h0000, 16'h0000);
        go(16'h0000, 16'h0000);
        wait_idle(500);
        push_ramp(16'h0000, 16'hFFFF, 16'h0000);
        go(16'hFFFF, 16'h0000);
        wait_idle(500);
        chk("fs_cur", dac_code_cur, 16'hFFFF);
        d0 = n_done;
        push_ramp(16'hFFFF, 16'hFFFF, 16'h0010);
        go(16'hFFFF, 16'h0010);
        wait_idle(500);
        chk("same_done", n_done - d0, 1);
        chk("same_q", exp_q.size(), 0);

        // no spi_ok: timeout after exactly TIMEOUT_CYC clocks
        ok_en = 1'b0;
        d0 = n_done;
        push_ramp(16'hFFFF, 16'h1234, 16'h0000);
        go(16'h1234, 16'h0000);
        wait_wr(10);
        n = 0;
        while (!timeout_err && n < 1100) begin
            tick(1);
            n++;
        end
        chk("tmo_cycles", n, 1000);
        chk("tmo_busy", ramp_busy, 0);
        chk("tmo_cur", dac_code_cur, 16'hFFFF);
        chk("tmo_done", n_done - d0, 0);
        ok_en = 1'b1;
        push_ramp(16'hFFFF, 16'hFFFF, 16'h0000);
        go(16'hFFFF, 16'h0000);
        tick(1);
        chk("tmo_clear", timeout_err, 0);
        wait_idle(500);

        // retarget during WAIT_OK
        push_ramp(16'hFFFF, 16'h8000, 16'h0000);
        go(16'h8000, 16'h0000);
        wait_idle(500);
        ok_delay = 20;
        d0 = n_done;
        exp_q.push_back(16'h8040);
        go(16'h8100, 16'h0040);
        wait_wr(10);
        tick(5);
        push_ramp(16'h8040, 16'h7F00, 16'h0040);
        go(16'h7F00, 16'h0040);
        wait_idle(3000);
        chk("rt_cur", dac_code_cur, 16'h7F00);
        chk("rt_done", n_done - d0, 1);
        chk("rt_q", exp_q.size(), 0);

        // reset while holding between writes, then a stray spi_ok
        ok_delay = 5;
        d0 = n_done;
        exp_q.push_back(16'h7F40);
        go(16'h7F80, 16'h0040);
        tick(20);
        chk("hold_busy", ramp_busy, 1);
        chk("hold_cur", dac_code_cur, 16'h7F40);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        man_ok = 1'b1;
        tick(1);
        man_ok = 1'b0;
        tick(150);
        chk("hr_cur", dac_code_cur, 16'h8000);
        chk("hr_busy", ramp_busy, 0);
        chk("hr_data", bus.data_in, 16'h0000);
        chk("hr_done", n_done - d0, 0);
        chk("hr_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
